bcd_down_timer: RTL and testbench

//   Multi-digit BCD countdown timer (race clock / fuel gauge), the count-down

---
 rtl/bcd_down_timer_pkg.sv | 19 +
 rtl/bcd_down_digit.sv | 28 ++
 rtl/bcd_down_timer.sv | 124 ++++++++++++
 tb/tb_bcd_down_timer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer: digit limits, FSM state
// encodings and the per-nibble clamp applied to every externally supplied value.
package bcd_down_timer_pkg;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // FSM encodings kept as plain 2-bit constants so older blocks can share them
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Any nibble outside 0..9 is forced to 9 so the register bank only ever
   // holds legal BCD digits and the borrow logic never sees A..F.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      bcd_clamp = (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain. Purely combinational: given the
// current digit and the borrow arriving from the lower digits, produce the
// digit value to be registered on the next edge.
module bcd_down_digit
   import bcd_down_timer_pkg::*;
(
   input  logic [3:0] cur,
   input  logic       dec_en,
   input  logic       borrow_in,
   output logic [3:0] nxt,
   output logic       is_zero
);

   // A digit steps only when the whole counter decrements and every lower
   // digit is 0; stepping below 0 wraps to 9 and passes the borrow upward.
   always_comb begin
      nxt = cur;
      if (dec_en && borrow_in) begin
         if (cur == BCD_ZERO)
            nxt = BCD_MAX;
         else
            nxt = cur - 4'd1;
      end
   end

   assign is_zero = (cur == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer. Loads a BCD start value, counts down once
// per qualified tick while running, and pulses expired for one clock when the
// count lands on zero. All outputs come straight from registers.
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int                  DIGITS     = 4,
   parameter logic [4*DIGITS-1:0] INIT_VALUE = 16'h0030
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  tick,
   output logic [4*DIGITS-1:0]   value,
   output logic                  zero,
   output logic                  running,
   output logic                  expired
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]      value_q;
   logic [W-1:0]      value_d;
   logic [W-1:0]      dec_value;
   logic [W-1:0]      load_clamped;
   logic [W-1:0]      init_clamped;
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              zero_q;
   logic              expired_q;
   logic              expired_d;
   logic              dec_en;
   logic              value_is_zero;
   logic [DIGITS-1:0] borrow;
   logic [DIGITS-1:0] digit_zero;

   // Digit 0 always sees a borrow; higher digits only when everything below is 0.
   assign borrow[0] = 1'b1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_down_digit u_digit (
            .cur       (value_q[4*i +: 4]),
            .dec_en    (dec_en),
            .borrow_in (borrow[i]),
            .nxt       (dec_value[4*i +: 4]),
            .is_zero   (digit_zero[i])
         );

         assign load_clamped[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
         assign init_clamped[4*i +: 4] = bcd_clamp(INIT_VALUE[4*i +: 4]);

         if (i > 0) begin : g_borrow
            assign borrow[i] = borrow[i-1] & digit_zero[i-1];
         end
      end
   endgenerate

   assign value_is_zero = &digit_zero;

   // The count only moves on an uncontested tick in RUN. Gating on a nonzero
   // value as well guarantees the counter can never wrap to 99..9.
   assign dec_en = (state_q == ST_RUN) & tick & ~load & ~pause & ~value_is_zero;

   // Next-state decode with priority load > pause > start > tick.
   always_comb begin
      value_d   = value_q;
      state_d   = state_q;
      expired_d = 1'b0;
      if (load) begin
         value_d = load_clamped;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!pause && start && !value_is_zero)
                  state_d = ST_RUN;
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_IDLE;
               end else if (dec_en) begin
                  value_d = dec_value;
                  if (dec_value == '0) begin
                     state_d   = ST_DONE;
                     expired_d = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, count and flag registers; reset forces the clamped power-on value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q   <= init_clamped;
         zero_q    <= (init_clamped == '0);
         state_q   <= ST_IDLE;
         expired_q <= 1'b0;
      end else begin
         value_q   <= value_d;
         zero_q    <= (value_d == '0);
         state_q   <= state_d;
         expired_q <= expired_d;
      end
   end

   assign value   = value_q;
   assign zero    = zero_q;
   assign running = (state_q == ST_RUN);
   assign expired = expired_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: inputs change 1ns after a rising edge,
// outputs are sampled at the same offset after the following edge.
module tb_bcd_down_timer;

   logic        clk;
   logic        reset_n;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic        tick;
   logic [15:0] value;
   logic        zero;
   logic        running;
   logic        expired;

   int n_checks;
   int n_pass;

   bcd_down_timer #(.DIGITS(4), .INIT_VALUE(16'h0030)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .pause      (pause),
      .tick       (tick),
      .value      (value),
      .zero       (zero),
      .running    (running),
      .expired    (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1; load_value = v;
      step();
      load = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      reset_n    = 1'b1;
      load_value = 16'h0000;
      idle_inputs();

      // Reset state
      #1 reset_n = 1'b0;
      #1;
      check("rst_value",   value,   16'h0030);
      check("rst_zero",    zero,    1'b0);
      check("rst_running", running, 1'b0);
      check("rst_expired", expired, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_value", value, 16'h0030);

      // Multi-digit borrow from 0100
      do_load(16'h0100);
      check("ld100_value",   value,   16'h0100);
      check("ld100_running", running, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      check("run_started", running, 1'b1);
      tick = 1'b1; step();
      check("tick_0099", value, 16'h0099);
      for (int i = 0; i < 9; i++) step();
      check("tick_0090", value, 16'h0090);
      step();
      check("tick_0089", value, 16'h0089);
      tick = 1'b0; step();
      check("no_tick_hold", value, 16'h0089);

      // Borrow through all four digits
      do_load(16'h1000);
      start = 1'b1; step(); start = 1'b0;
      tick = 1'b1; step(); tick = 1'b0;
      check("borrow_0999", value, 16'h0999);

      // Expiry
      do_load(16'h0002);
      start = 1'b1; step(); start = 1'b0;
      tick = 1'b1; step();
      check("exp_v1",    value,   16'h0001);
      check("exp_pre",   expired, 1'b0);
      step();
      check("exp_v0",    value,   16'h0000);
      check("exp_pulse", expired, 1'b1);
      check("exp_run",   running, 1'b0);
      check("exp_zero",  zero,    1'b1);
      step();
      check("done_v0",   value,   16'h0000);
      check("done_exp",  expired, 1'b0);
      start = 1'b1; pause = 1'b1; step();
      start = 1'b0; pause = 1'b0; tick = 1'b0;
      check("done_hold_v",   value,   16'h0000);
      check("done_hold_run", running, 1'b0);
      check("done_hold_exp", expired, 1'b0);

      // Nibble clamp and start at zero
      do_load(16'h12A4);
      check("clamp_value", value, 16'h1294);
      check("clamp_zero",  zero,  1'b0);
      do_load(16'h0000);
      check("ld0_zero", zero, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      check("start0_run", running, 1'b0);

      // Priority: load over tick, pause over tick, start over tick
      do_load(16'h0050);
      start = 1'b1; step(); start = 1'b0;
      check("p_run50", running, 1'b1);
      load = 1'b1; load_value = 16'h0777; tick = 1'b1; step();
      load = 1'b0; tick = 1'b0;
      check("p_ldtick_v",   value,   16'h0777);
      check("p_ldtick_run", running, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      check("p_run777", running, 1'b1);
      pause = 1'b1; tick = 1'b1; step();
      pause = 1'b0; tick = 1'b0;
      check("p_pause_v",   value,   16'h0777);
      check("p_pause_run", running, 1'b0);
      start = 1'b1; tick = 1'b1; step();
      start = 1'b0;
      check("p_starttick_v",   value,   16'h0777);
      check("p_starttick_run", running, 1'b1);
      step(); tick = 1'b0;
      check("p_tick_776", value, 16'h0776);

      // Asynchronous reset mid-run
      do_load(16'h0042);
      start = 1'b1; step(); start = 1'b0;
      check("ar_run", running, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("ar_value",   value,   16'h0030);
      check("ar_running", running, 1'b0);
      check("ar_zero",    zero,    1'b0);
      step();
      reset_n = 1'b1;
      step();
      start = 1'b1; step(); start = 1'b0;
      check("ar_restart", running, 1'b1);
      tick = 1'b1; step(); tick = 1'b0;
      check("ar_tick_0029", value, 16'h0029);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
